// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the registered priority encoder.
//   pe_mode_e : encoder mode (fixed MSB-first or round-robin)
//   pe_vec_w  : request vector width for a given index width
//   rotr      : rotate the low w bits of a vector right by amt
package prio_enc_pkg;

  typedef enum logic {PE_FIXED = 1'b0, PE_RR = 1'b1} pe_mode_e;

  // Largest supported vector (N up to 6).
  localparam int unsigned PE_MAX_W = 64;

  function automatic int unsigned pe_vec_w(input int unsigned n);
    return 32'(1) << n;
  endfunction

  // Rotate right within the low w bits: r[i] = v[(i + amt) mod w].
  function automatic logic [PE_MAX_W-1:0] rotr(input logic [PE_MAX_W-1:0] v,
                                               input int unsigned amt,
                                               input int unsigned w);
    logic [PE_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < PE_MAX_W; i++) begin
      if (i < w) r[i] = v[6'((i + amt) % w)];
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational MSB-first priority encoder.
//   v   : request vector (2**N bits)
//   idx : index of the highest set bit (0 when v is zero)
//   any : v is nonzero
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = pe_vec_w(N)
) (
  input  logic [W-1:0] v,
  output logic [N-1:0] idx,
  output logic         any
);

  // Ascending scan; the last hit is the highest set index.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (v[i]) idx = N'(i);
    end
  end

  assign any = |v;

endmodule

// File: rtl/prio_enc_rr.sv
// Registered priority encoder with fixed / round-robin modes and a
// valid/ready handshake on both sides.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request vector handshake (in_ready is combinational)
//   d, mode             : request vector and mode, sampled on capture
//   y_valid / y_ready   : result handshake
//   y_idx, y_any        : winning index, captured vector was nonzero
//   y_onehot            : 1 << y_idx when y_any (only with PRIO_ENC_ONEHOT_EN)
module prio_enc_rr
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N       = 4,
  parameter  int unsigned RST_PTR = pe_vec_w(N) - 1,
  localparam int unsigned W       = pe_vec_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] d,
  input  logic         mode,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [N-1:0] y_idx,
  output logic         y_any
`ifdef PRIO_ENC_ONEHOT_EN
  ,
  output logic [W-1:0] y_onehot
`endif
);

  logic [N-1:0] ptr;
  pe_mode_e     mode_c;
  logic [N-1:0] rot_amt_c;
  logic [W-1:0] rot_c;
  logic [N-1:0] core_idx_c;
  logic         core_any_c;
  logic [N-1:0] win_c;
  logic         capture_c;

  assign mode_c    = pe_mode_e'(mode);
  assign in_ready  = !y_valid || y_ready;
  assign capture_c = in_valid && in_ready;

  // Rotating right by ptr+1 puts index ptr at the MSB, so the MSB-first
  // core searches ptr, ptr-1, ..., ptr+1; fixed mode rotates by 0.
  assign rot_amt_c = (mode_c == PE_RR) ? N'(ptr + N'(1)) : '0;
  assign rot_c     = W'(rotr(64'(d), 32'(rot_amt_c), W));

  prio_enc_core #(.N(N)) u_core (
    .v   (rot_c),
    .idx (core_idx_c),
    .any (core_any_c)
  );

  assign win_c = N'(core_idx_c + rot_amt_c);

  // One-entry result register; a capture overwrites any result leaving this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid  <= 1'b0;
      y_idx    <= '0;
      y_any    <= 1'b0;
      ptr      <= N'(RST_PTR);
`ifdef PRIO_ENC_ONEHOT_EN
      y_onehot <= '0;
`endif
    end else if (capture_c) begin
      y_valid  <= 1'b1;
      y_idx    <= core_any_c ? win_c : '0;
      y_any    <= core_any_c;
`ifdef PRIO_ENC_ONEHOT_EN
      y_onehot <= core_any_c ? (W'(1) << win_c) : '0;
`endif
      // Winner drops to lowest priority; zero vectors leave ptr alone.
      if (mode_c == PE_RR && core_any_c) ptr <= N'(win_c - N'(1));
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule
